// File: rtl/lcd_status_writer.sv
// HD44780 4-bit status writer: power-on init, then 2x16 frames rendered
// from a registered input snapshot, redrawn on change or refresh.
module lcd_status_writer #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int N_DIGITS = 4,
   parameter int TRIAL_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] digits_in,
   input  logic [3:0]            digit_cnt,
   input  logic                  mask,
   input  logic [TRIAL_W-1:0]    trials,
   input  logic [3:0]            state,
   input  logic                  refresh,
   output logic                  busy,
   output logic                  lcd_rs,
   output logic                  lcd_rw,
   output logic                  lcd_e,
   output logic [3:0]            lcd_db
);

   localparam int TICK = CLK_HZ / 1_000_000;

   localparam logic [1:0] S_PWR   = 2'd0;
   localparam logic [1:0] S_INIT  = 2'd1;
   localparam logic [1:0] S_FRAME = 2'd2;
   localparam logic [1:0] S_IDLE  = 2'd3;

   localparam logic [2:0] P_LOAD = 3'd0;
   localparam logic [2:0] P_SET  = 3'd1;
   localparam logic [2:0] P_EHI  = 3'd2;
   localparam logic [2:0] P_ELO  = 3'd3;
   localparam logic [2:0] P_POST = 3'd4;

   localparam logic [31:0] PW_S  = "PW: ";
   localparam logic [31:0] TRY_S = "TRY:";

   function automatic logic [31:0] us(input int n);
      return 32'(n * TICK - 1);
   endfunction

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   logic [1:0]            mst;
   logic [2:0]            ph;
   logic [31:0]           tmr;
   logic [5:0]            idx;
   logic                  nib_lo;
   logic                  pending;

   logic [4*N_DIGITS-1:0] sn_dig;
   logic [3:0]            sn_cnt;
   logic                  sn_mask;
   logic [TRIAL_W-1:0]    sn_tri;
   logic [3:0]            sn_st;

   logic                  tdone;
   logic                  trig;
   logic                  start;
   logic                  init_nib;
   logic                  cur_rs;
   logic [7:0]            cur_byte;
   logic [3:0]            nib;
   int                    post_us;

   logic [3:0]            dcl;
   logic [5:0]            p1;
   logic [5:0]            p2;
   logic [7:0]            ln1;
   logic [7:0]            ln2;
   logic [7:0]            tri_c;
   logic [63:0]           msg_w;
   logic [7:0]            fbyte;

   assign tdone  = (tmr == '0);
   assign busy   = (mst != S_IDLE);
   assign lcd_rw = 1'b0;

   assign trig = refresh
      || ({digits_in, digit_cnt, mask, trials, state}
          != {sn_dig, sn_cnt, sn_mask, sn_tri, sn_st});

   // Frame text, rendered only from the snapshot
   always_comb begin
      dcl = (sn_cnt > 4'(N_DIGITS)) ? 4'(N_DIGITS) : sn_cnt;
      p1  = idx - 6'd1;
      p2  = idx - 6'd18;
      ln1 = 8'h20;
      ln2 = 8'h20;
      for (int k = 0; k < 4; k++)
         if (p1 == 6'(k)) ln1 = PW_S[8*(3-k) +: 8];
      for (int i = 0; i < N_DIGITS; i++)
         if (p1 == 6'(4 + i)) begin
            if (4'(i) >= dcl)
               ln1 = 8'h5F;
            else if (sn_mask)
               ln1 = 8'h2A;
            else
               ln1 = hexc(sn_dig[4*(N_DIGITS-1-i) +: 4]);
         end
      case (sn_st)
         4'd0:    msg_w = "LOCKED  ";
         4'd1:    msg_w = "ENTER   ";
         4'd2:    msg_w = "OPEN    ";
         4'd3:    msg_w = "WRONG   ";
         4'd4:    msg_w = "ALARM   ";
         default: msg_w = "--------";
      endcase
      if (32'(sn_tri) <= 32'd9)
         tri_c = 8'h30 + 8'(sn_tri);
      else
         tri_c = 8'h2B;
      for (int k = 0; k < 8; k++)
         if (p2 == 6'(k)) ln2 = msg_w[8*(7-k) +: 8];
      for (int k = 0; k < 4; k++)
         if (p2 == 6'(8 + k)) ln2 = TRY_S[8*(3-k) +: 8];
      if (p2 == 6'd12) ln2 = tri_c;
      if (idx == 6'd0)
         fbyte = 8'h80;
      else if (idx < 6'd17)
         fbyte = ln1;
      else if (idx == 6'd17)
         fbyte = 8'hC0;
      else
         fbyte = ln2;
   end

   always_comb begin
      init_nib = (mst == S_INIT) && (idx < 6'd4);
      cur_rs   = 1'b0;
      cur_byte = fbyte;
      post_us  = 40;
      if (mst == S_INIT) begin
         unique case (idx[2:0])
            3'd0: cur_byte = 8'h03;
            3'd1: cur_byte = 8'h03;
            3'd2: cur_byte = 8'h03;
            3'd3: cur_byte = 8'h02;
            3'd4: cur_byte = 8'h28;
            3'd5: cur_byte = 8'h0C;
            3'd6: cur_byte = 8'h06;
            3'd7: cur_byte = 8'h01;
         endcase
      end else begin
         cur_rs = (idx != 6'd0) && (idx != 6'd17);
      end
      if (init_nib)
         post_us = (idx == 6'd0) ? 4100 : (idx == 6'd1) ? 100 : 40;
      else if (!cur_rs && cur_byte == 8'h01)
         post_us = 1640;
      nib = (init_nib || nib_lo) ? cur_byte[3:0] : cur_byte[7:4];
   end

   always_comb begin
      start = 1'b0;
      unique case (1'b1)
         mst == S_IDLE:
            start = trig;
         tdone && ph == P_POST && mst == S_INIT:
            start = (idx == 6'd7);
         tdone && ph == P_POST && mst == S_FRAME:
            start = (idx == 6'd33) && (pending || trig);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sn_dig  <= '0;
         sn_cnt  <= '0;
         sn_mask <= 1'b0;
         sn_tri  <= '0;
         sn_st   <= '0;
         pending <= 1'b0;
      end else begin
         if (start) begin
            sn_dig  <= digits_in;
            sn_cnt  <= digit_cnt;
            sn_mask <= mask;
            sn_tri  <= trials;
            sn_st   <= state;
            pending <= 1'b0;
         end else if (mst != S_IDLE && trig) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mst    <= S_PWR;
         ph     <= P_POST;
         tmr    <= us(15000);
         idx    <= '0;
         nib_lo <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_e  <= 1'b0;
         lcd_db <= '0;
      end else begin
         if (mst != S_IDLE && !tdone) begin
            tmr <= tmr - 32'd1;
         end else if (mst != S_IDLE) begin
            unique case (ph)
               P_LOAD: begin
                  lcd_rs <= cur_rs;
                  lcd_db <= nib;
                  ph     <= P_SET;
                  tmr    <= us(1);
               end
               P_SET: begin
                  lcd_e <= 1'b1;
                  ph    <= P_EHI;
                  tmr   <= us(1);
               end
               P_EHI: begin
                  lcd_e <= 1'b0;
                  ph    <= P_ELO;
                  tmr   <= us(1);
               end
               P_ELO: begin
                  if (!init_nib && !nib_lo) begin
                     nib_lo <= 1'b1;
                     ph     <= P_LOAD;
                  end else begin
                     ph  <= P_POST;
                     tmr <= us(post_us);
                  end
               end
               default: begin
                  nib_lo <= 1'b0;
                  ph     <= P_LOAD;
                  if (mst == S_PWR) begin
                     mst <= S_INIT;
                     idx <= '0;
                  end else if (mst == S_FRAME && idx == 6'd33) begin
                     mst <= S_IDLE;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            endcase
         end
         // A frame start overrides whatever the sequencer chose above
         if (start) begin
            mst    <= S_FRAME;
            idx    <= '0;
            ph     <= P_LOAD;
            tmr    <= '0;
            nib_lo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcd_status_writer.sv
// Bench for lcd_status_writer: captures nibbles on E falling edges and
// compares whole frames against a string-level model of the display.
module tb_lcd_status_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  digit_cnt = '0;
   logic        mask = 1'b0;
   logic [3:0]  trials = '0;
   logic [3:0]  state = '0;
   logic        refresh = 1'b0;
   logic        busy;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_e;
   logic [3:0]  lcd_db;

   int checks = 0;
   int failures = 0;
   int busy_low = 0;
   bit dead = 1'b0;
   logic [4:0] nq[$];

   lcd_status_writer #(
      .CLK_HZ(1_000_000),
      .N_DIGITS(4),
      .TRIAL_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .digits_in(digits_in),
      .digit_cnt(digit_cnt),
      .mask(mask),
      .trials(trials),
      .state(state),
      .refresh(refresh),
      .busy(busy),
      .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw),
      .lcd_e(lcd_e),
      .lcd_db(lcd_db)
   );

   always #5 clk = ~clk;

   always @(negedge lcd_e) if (rst_n) nq.push_back({lcd_rs, lcd_db});
   always @(negedge clk) if (rst_n && !busy) busy_low++;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] str2v(input string s);
      logic [127:0] v = '0;
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s.getc(i);
      return v;
   endfunction

   function automatic logic [127:0] m_l1(input logic [15:0] d,
                                         input int cnt, input bit m);
      string hexs = "0123456789ABCDEF";
      string s = "PW: ";
      int n = (cnt > 4) ? 4 : cnt;
      for (int i = 0; i < 4; i++) begin
         int v = int'((d >> (12 - 4 * i)) & 16'hF);
         if (i >= n) s = {s, "_"};
         else if (m) s = {s, "*"};
         else s = {s, hexs.substr(v, v)};
      end
      while (s.len() < 16) s = {s, " "};
      return str2v(s);
   endfunction

   function automatic logic [127:0] m_l2(input int st, input int tr);
      string s;
      case (st)
         0: s = "LOCKED";
         1: s = "ENTER";
         2: s = "OPEN";
         3: s = "WRONG";
         4: s = "ALARM";
         default: s = "--------";
      endcase
      while (s.len() < 8) s = {s, " "};
      s = {s, "TRY:"};
      s = {s, (tr <= 9) ? $sformatf("%0d", tr) : "+"};
      while (s.len() < 16) s = {s, " "};
      return str2v(s);
   endfunction

   task automatic get_nib(output logic [4:0] v);
      int n = 0;
      v = '0;
      if (dead) return;
      while (nq.size() == 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("nib_arrive", 128'(nq.size() > 0), 128'(1));
      if (nq.size() == 0) dead = 1'b1;
      else v = nq.pop_front();
   endtask

   task automatic get_byte(output logic [8:0] b);
      logic [4:0] hi;
      logic [4:0] lo;
      get_nib(hi);
      get_nib(lo);
      b = {(hi[4] == lo[4]) ? hi[4] : 1'bx, hi[3:0], lo[3:0]};
   endtask

   task automatic apply(input logic [15:0] d, input int cnt, input bit m,
                        input int tr, input int st, input bit rf);
      @(negedge clk);
      digits_in = d;
      digit_cnt = 4'(cnt);
      mask = m;
      trials = 4'(tr);
      state = 4'(st);
      refresh = rf;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic frame(input string tag, input int poke_at,
                        input logic [15:0] d, input int cnt, input bit m,
                        input int tr, input int st);
      logic [8:0]   b;
      logic [7:0]   c1 = '0;
      logic [7:0]   c2 = '0;
      logic [127:0] l1 = '0;
      logic [127:0] l2 = '0;
      logic [33:0]  rsv = '0;
      logic [33:0]  ers = '0;
      for (int i = 0; i < 34; i++) begin
         get_byte(b);
         rsv[33-i] = b[8];
         ers[33-i] = (i != 0 && i != 17);
         if (i == 0) c1 = b[7:0];
         else if (i < 17) l1[8*(16-i) +: 8] = b[7:0];
         else if (i == 17) c2 = b[7:0];
         else l2[8*(33-i) +: 8] = b[7:0];
         if (i == poke_at) begin
            @(negedge clk);
            state = 4'd2;
            refresh = 1'b1;
            @(negedge clk);
            refresh = 1'b0;
         end
      end
      chk({tag, ".cmd80"}, 128'(c1), 128'(8'h80));
      chk({tag, ".cmdC0"}, 128'(c2), 128'(8'hC0));
      chk({tag, ".rs"}, 128'(rsv), 128'(ers));
      chk({tag, ".line1"}, l1, m_l1(d, cnt, m));
      chk({tag, ".line2"}, l2, m_l2(st, tr));
   endtask

   task automatic go_idle(input string tag, input int bound);
      int n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".idle"}, 128'(busy), 128'(0));
   endtask

   task automatic chk_init(input string tag);
      int n = 0;
      logic [4:0]  a;
      logic [8:0]  b;
      logic [19:0] an = '0;
      logic [35:0] bn = '0;
      while (!lcd_e && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".pwr_wait"}, 128'(n >= 15000 && n < 16000), 128'(1));
      for (int i = 0; i < 4; i++) begin
         get_nib(a);
         an = {an[14:0], a};
      end
      chk({tag, ".init_nib"}, 128'(an), 128'({5'h03, 5'h03, 5'h03, 5'h02}));
      for (int i = 0; i < 4; i++) begin
         get_byte(b);
         bn = {bn[26:0], b};
      end
      chk({tag, ".init_byte"}, 128'(bn),
          128'({9'h028, 9'h00C, 9'h006, 9'h001}));
   endtask

   initial begin
      logic [15:0] rd;
      int rc, rm, rt, rs;
      int n;
      repeat (3) @(negedge clk);
      chk("rst.pins", 128'({lcd_rs, lcd_rw, lcd_e, lcd_db}), 128'(0));
      chk("rst.busy", 128'(busy), 128'(1));
      rst_n = 1'b1;

      chk_init("t1");
      frame("t1", -1, 16'h0, 0, 1'b0, 0, 0);
      chk("t1.busy_tail", 128'(busy), 128'(1));
      go_idle("t1", 200);

      apply(16'h1A2F, 4, 1'b0, 0, 0, 1'b0);
      frame("t2", -1, 16'h1A2F, 4, 1'b0, 0, 0);
      go_idle("t2", 200);

      apply(16'h1A2F, 2, 1'b1, 0, 0, 1'b0);
      frame("t3a", -1, 16'h1A2F, 2, 1'b1, 0, 0);
      go_idle("t3a", 200);
      apply(16'h1A2F, 9, 1'b0, 0, 0, 1'b0);
      frame("t3b", -1, 16'h1A2F, 9, 1'b0, 0, 0);
      go_idle("t3b", 200);

      apply(16'h1A2F, 4, 1'b0, 2, 3, 1'b0);
      frame("t4a", -1, 16'h1A2F, 4, 1'b0, 2, 3);
      go_idle("t4a", 200);
      apply(16'h1A2F, 4, 1'b0, 12, 9, 1'b0);
      frame("t4b", -1, 16'h1A2F, 4, 1'b0, 12, 9);
      go_idle("t4b", 200);

      apply(16'h1234, 3, 1'b0, 1, 1, 1'b0);
      frame("t5p", -1, 16'h1234, 3, 1'b0, 1, 1);
      go_idle("t5p", 200);
      apply(16'h1234, 3, 1'b0, 1, 1, 1'b1);
      busy_low = 0;
      frame("t5a", 10, 16'h1234, 3, 1'b0, 1, 1);
      frame("t5b", -1, 16'h1234, 3, 1'b0, 1, 2);
      chk("t5.no_gap", 128'(busy_low), 128'(0));
      go_idle("t5", 200);
      repeat (100) @(negedge clk);
      chk("t5.no_extra", 128'(nq.size()), 128'(0));

      for (int r = 0; r < 3; r++) begin
         rd = 16'($urandom);
         rc = int'($urandom_range(0, 15));
         rm = int'($urandom_range(0, 1));
         rt = int'($urandom_range(0, 15));
         rs = int'($urandom_range(0, 7));
         apply(rd, rc, rm[0], rt, rs, 1'b1);
         frame($sformatf("rnd%0d", r), -1, rd, rc, rm[0], rt, rs);
         go_idle($sformatf("rnd%0d", r), 200);
      end

      apply(16'hBEEF, 4, 1'b0, 3, 4, 1'b1);
      repeat (300) @(negedge clk);
      n = 0;
      while (!lcd_e && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6.e_high", 128'(lcd_e), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("t6.pins", 128'({lcd_rs, lcd_rw, lcd_e, lcd_db}), 128'(0));
      chk("t6.busy", 128'(busy), 128'(1));
      repeat (2) @(negedge clk);
      nq.delete();
      rst_n = 1'b1;
      chk_init("t6");
      frame("t6", -1, 16'hBEEF, 4, 1'b0, 3, 4);
      go_idle("t6", 4000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
